keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 183 ++++++++++++++++++
 tb/tb_keypad_emulator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Keypad matrix emulator: presses one key per command (bounce, hold, bounce, gap); optional bounce via KEYPAD_EMULATOR_BOUNCE_EN.
// Latency: press starts the cycle after the handshake; col_values follows row_values combinationally.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are dropped, never queued.
module keypad_emulator #(
    parameter int         BOUNCE_CYCLES = 64,
    parameter int         GAP_CYCLES    = 256,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic [3:0]  row_values,
    output logic [3:0]  col_values,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  key_q;
    logic        closed;
    logic [3:0]  key_pos;

    if (GAP_CYCLES < 1 || GAP_CYCLES > 65536) begin : g_bad_gap
        $error("GAP_CYCLES out of range");
    end
    if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 65536) begin : g_bad_bounce
        $error("BOUNCE_CYCLES out of range");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    // A zero hold still closes the contact for one cycle.
    function automatic logic [15:0] hold_load(input logic [15:0] h);
        return (h == 16'd0) ? 16'd0 : h - 16'd1;
    endfunction

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES - 1);

    logic [7:0]  lfsr;
    logic [7:0]  lfsr_step;
    logic [15:0] hold_q;

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

    assign cmd_ready = ~busy;

    // Key position encoded as {row[1:0], col[1:0]}.
    always_comb begin
        key_pos = 4'b0000;
        case (key_q)
            4'h1: key_pos = 4'b0000;
            4'h2: key_pos = 4'b0001;
            4'h3: key_pos = 4'b0010;
            4'hA: key_pos = 4'b0011;
            4'h4: key_pos = 4'b0100;
            4'h5: key_pos = 4'b0101;
            4'h6: key_pos = 4'b0110;
            4'hB: key_pos = 4'b0111;
            4'h7: key_pos = 4'b1000;
            4'h8: key_pos = 4'b1001;
            4'h9: key_pos = 4'b1010;
            4'hC: key_pos = 4'b1011;
            4'hE: key_pos = 4'b1100;
            4'h0: key_pos = 4'b1101;
            4'hF: key_pos = 4'b1110;
            4'hD: key_pos = 4'b1111;
        endcase
    end

    // An x/z row bit fails the if and leaves the column open.
    always_comb begin
        col_values = 4'b0000;
        if (closed && row_values[key_pos[3:2]] == 1'b1)
            col_values[key_pos[1:0]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            key_q  <= '0;
            closed <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            hold_q <= '0;
            lfsr   <= LFSR_SEED;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        key_q <= cmd_key;
                        busy  <= 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                        hold_q <= cmd_hold;
                        state  <= BOUNCE_IN;
                        cnt    <= BOUNCE_LOAD;
                        closed <= lfsr[0];
`else
                        state  <= HOLD;
                        cnt    <= hold_load(cmd_hold);
                        closed <= 1'b1;
`endif
                    end
                end
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
                BOUNCE_IN: begin
                    lfsr <= lfsr_step;
                    if (cnt == 16'd0) begin
                        state  <= HOLD;
                        cnt    <= hold_load(hold_q);
                        closed <= 1'b1;
                    end else begin
                        cnt    <= cnt - 16'd1;
                        closed <= lfsr_step[0];
                    end
                end
                HOLD: begin
                    if (cnt == 16'd0) begin
                        state  <= BOUNCE_OUT;
                        cnt    <= BOUNCE_LOAD;
                        closed <= lfsr[0];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                BOUNCE_OUT: begin
                    lfsr <= lfsr_step;
                    if (cnt == 16'd0) begin
                        state  <= GAP;
                        cnt    <= GAP_LOAD;
                        closed <= 1'b0;
                        done   <= (GAP_CYCLES == 1);
                    end else begin
                        cnt    <= cnt - 16'd1;
                        closed <= lfsr_step[0];
                    end
                end
`else
                HOLD: begin
                    if (cnt == 16'd0) begin
                        state  <= GAP;
                        cnt    <= GAP_LOAD;
                        closed <= 1'b0;
                        done   <= (GAP_CYCLES == 1);
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`endif
                // done is high during the final GAP cycle, so ready rises right after it.
                GAP: begin
                    if (cnt == 16'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt  <= cnt - 16'd1;
                        done <= (cnt == 16'd1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    closed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: per-cycle scoreboard driven by a press-schedule model, plus key-map table and directed corners.
module tb_keypad_emulator;

    localparam int BC = 64;
    localparam int GC = 256;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    localparam int BOUNCE = 1;
`else
    localparam int BOUNCE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic [3:0]  row_values;
    logic [3:0]  col_values;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(BC), .GAP_CYCLES(GC), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .row_values(row_values),
        .col_values(col_values), .busy(busy), .done(done)
    );

    // Model: each accepted command expands into a list of per-cycle {closed, done} slots.
    typedef struct packed { logic closed; logic done; } slot_t;
    slot_t      sched[$];
    int         m_row, m_col, m_ones;
    logic [7:0] m_lfsr;
    logic [3:0] layout [16];

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [3:0] key; logic [3:0] row; logic [3:0] col; } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        int v, fb;
        v  = int'(x);
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    task automatic push_bounce();
        for (int i = 0; i < BC; i++) begin
            sched.push_back('{m_lfsr[0], 1'b0});
            if (m_lfsr[0]) m_ones++;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic push_cmd(input logic [3:0] key, input logic [15:0] hold);
        int idx, h;
        idx = 0;
        for (int i = 0; i < 16; i++) if (layout[i] == key) idx = i;
        m_row  = idx / 4;
        m_col  = idx % 4;
        m_ones = 0;
        h = (hold == 16'd0) ? 1 : int'(hold);
        if (BOUNCE != 0) push_bounce();
        for (int i = 0; i < h; i++) sched.push_back('{1'b1, 1'b0});
        if (BOUNCE != 0) push_bounce();
        for (int i = 0; i < GC - 1; i++) sched.push_back('{1'b0, 1'b0});
        sched.push_back('{1'b0, 1'b1});
    endtask

    // Compare at negedge, advance the model at posedge, return just after it.
    task automatic step();
        logic e_closed, e_done, e_busy;
        logic [3:0] e_col;
        @(negedge clk);
        if (sched.size() == 0) begin
            e_closed = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        end else begin
            e_closed = sched[0].closed; e_done = sched[0].done; e_busy = 1'b1;
        end
        e_col = 4'b0000;
        if (e_closed && row_values[m_row] == 1'b1) e_col[m_col] = 1'b1;
        check("col_values", 32'(col_values), 32'(e_col));
        check("cmd_ready", 32'(cmd_ready), 32'(!e_busy));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        @(posedge clk);
        if (sched.size() > 0) void'(sched.pop_front());
        else if (cmd_valid) push_cmd(cmd_key, cmd_hold);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sched.size() != 0 && n < 5000) begin
            step();
            n++;
        end
        if (sched.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic press(input logic [3:0] key, input logic [15:0] hold, input logic [3:0] row,
                         input logic [3:0] exp_col, input string tag);
        int n_closed, done_at, ones, h;
        wait_idle();
        row_values = row; cmd_key = key; cmd_hold = hold; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        ones = m_ones;
        h = (hold == 16'd0) ? 1 : int'(hold);
        n_closed = 0; done_at = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (col_values == exp_col) n_closed++;
            if (done) done_at = k;
            step();
            if (sched.size() == 0) break;
        end
        check({tag, "_closed_cycles"}, 32'(n_closed), 32'(ones + h));
        check({tag, "_done_cycle"}, 32'(done_at), 32'(2 * BC * BOUNCE + h + GC));
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic prev_done;
        int   got;

        layout = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        tbl[0]  = '{4'h5, 4'b0010, 4'b0010};
        tbl[1]  = '{4'h5, 4'b1101, 4'b0000};
        tbl[2]  = '{4'hD, 4'b1000, 4'b1000};
        tbl[3]  = '{4'hD, 4'b0111, 4'b0000};
        tbl[4]  = '{4'h1, 4'b0001, 4'b0001};
        tbl[5]  = '{4'hA, 4'b1111, 4'b1000};
        tbl[6]  = '{4'hE, 4'b1000, 4'b0001};
        tbl[7]  = '{4'h0, 4'b1000, 4'b0010};
        tbl[8]  = '{4'hF, 4'b1100, 4'b0100};
        tbl[9]  = '{4'h9, 4'b0100, 4'b0100};
        tbl[10] = '{4'hC, 4'b0100, 4'b1000};
        tbl[11] = '{4'h7, 4'b0011, 4'b0000};
        tbl[12] = '{4'hB, 4'b0010, 4'b1000};
        tbl[13] = '{4'h3, 4'b0001, 4'b0100};
        tbl[14] = '{4'h6, 4'b1110, 4'b0100};
        tbl[15] = '{4'h8, 4'b0100, 4'b0010};

        m_lfsr = 8'hA5; m_row = 0; m_col = 0; m_ones = 0;
        reset = 1'b0; cmd_valid = 1'b0; cmd_key = 4'h0; cmd_hold = 16'd0; row_values = 4'b1111;

        // Reset values with every row driven.
        repeat (2) @(posedge clk);
        #1;
        check("rst_col", 32'(col_values), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset = 1'b1;
        repeat (3) step();

        // Key map table: read back the column a few cycles into HOLD.
        for (int i = 0; i < 16; i++) begin
            wait_idle();
            row_values = tbl[i].row; cmd_key = tbl[i].key; cmd_hold = 16'd8; cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            repeat (BC * BOUNCE + 3) step();
            check($sformatf("table_col[%0d]", i), 32'(col_values), 32'(tbl[i].col));
        end

        // Hold counts and done position, including zero hold.
        press(4'h5, 16'd10, 4'b0010, 4'b0010, "hold10");
        press(4'hD, 16'd0,  4'b1000, 4'b1000, "hold0");
        press(4'h1, 16'd100, 4'b0001, 4'b0001, "hold100");

        // One-hot row scan during HOLD of key D.
        wait_idle();
        row_values = 4'b0000; cmd_key = 4'hD; cmd_hold = 16'd40; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (BC * BOUNCE + 2) step();
        for (int j = 0; j < 8; j++) begin
            row_values = 4'b0001 << (j % 4);
            #1;
            check("scan_col", 32'(col_values), (j % 4 == 3) ? 32'h8 : 32'h0);
            step();
        end

        // Command held valid while busy: next handshake only after done.
        wait_idle();
        row_values = 4'b0011; cmd_key = 4'h1; cmd_hold = 16'd5; cmd_valid = 1'b1;
        step();
        cmd_key = 4'h6; cmd_hold = 16'd7;
        prev_done = 1'b0; got = 0;
        for (int k = 0; k < 2000 && got == 0; k++) begin
            if (cmd_ready) begin
                got = 1;
                check("ready_after_done", 32'(prev_done), 32'h1);
            end
            prev_done = done;
            step();
        end
        if (got == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL second_handshake: cmd_ready never rose, expected 1");
        end
        cmd_valid = 1'b0;
        wait_idle();

        // Reset in HOLD with the row driven: column drops at once, no done.
        row_values = 4'b0010; cmd_key = 4'h5; cmd_hold = 16'd50; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (BC * BOUNCE + 5) step();
        check("pre_rst_col", 32'(col_values), 32'h2);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_col", 32'(col_values), 32'h0);
        check("mid_rst_ready", 32'(cmd_ready), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        sched.delete();
        m_lfsr = 8'hA5;
        @(posedge clk);
        #1;
        check("mid_rst_done", 32'(done), 32'h0);
        #2 reset = 1'b1;
        repeat (4) step();
        press(4'h5, 16'd12, 4'b0010, 4'b0010, "after_rst");

        // Random traffic against the schedule model.
        for (int c = 0; c < 8000; c++) begin
            row_values = 4'($urandom);
            cmd_valid  = ($urandom_range(0, 3) != 0);
            cmd_key    = 4'($urandom);
            cmd_hold   = 16'($urandom_range(0, 24));
            step();
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
